// File: rtl/srio_nwr_scheduler_pkg.sv
// Shared types and constants for the SRIO NWRITE round-robin scheduler.
package srio_nwr_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    REQ       = 3'd2,
    XFER      = 3'd3,
    WAIT_DONE = 3'd4
  } sched_state_t;

  localparam int MAX_LEN = 256;
  localparam int TSIZE_W = 8;
  localparam int LEN_W   = 9;

  // Round a byte length up to the next 8-byte (one beat) multiple.
  function automatic logic [LEN_W:0] ceil8(input logic [LEN_W-1:0] len);
    return ({1'b0, len} + (LEN_W+1)'(7)) & ~(LEN_W+1)'(7);
  endfunction

endpackage

// File: rtl/srio_nwr_scheduler_if.sv
// Engine-side bundle: db_req job handshake, target address/size and AXIS stream.
interface srio_nwr_scheduler_if #(parameter int ADDR_W = 34);
  import srio_nwr_sched_pkg::*;

  logic                rapidIO_ready_in;
  logic                nwr_ready_in;
  logic                nwr_busy_in;
  logic                nwr_done_ack_in;
  logic                nwr_req_o;
  logic [ADDR_W-1:0]   user_addr_o;
  logic [TSIZE_W-1:0]  user_tsize_o;
  logic [63:0]         user_tdata_o;
  logic [7:0]          user_tkeep_o;
  logic                user_tvalid_o;
  logic                user_tlast_o;
  logic                user_tready_in;

  modport master (
    input  rapidIO_ready_in, nwr_ready_in, nwr_busy_in, nwr_done_ack_in, user_tready_in,
    output nwr_req_o, user_addr_o, user_tsize_o,
           user_tdata_o, user_tkeep_o, user_tvalid_o, user_tlast_o
  );

  modport slave (
    output rapidIO_ready_in, nwr_ready_in, nwr_busy_in, nwr_done_ack_in, user_tready_in,
    input  nwr_req_o, user_addr_o, user_tsize_o,
           user_tdata_o, user_tkeep_o, user_tvalid_o, user_tlast_o
  );
endinterface

// File: rtl/srio_nwr_scheduler_rr_arbiter.sv
// Combinational rotating-priority pick: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/srio_nwr_scheduler.sv
// Round-robin sharing of the db_req NWRITE engine between NUM_REQ sources.
// Optional WAIT_DONE watchdog: define SRIO_NWR_SCHED_TIMEOUT_EN.
module srio_nwr_scheduler
  import srio_nwr_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 34,
  parameter int WIN_LOG2    = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      log_clk,
  input  logic                      log_rst_n,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*9-1:0]      len_in,
  input  logic [NUM_REQ*ADDR_W-1:0] base_addr_in,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  input  logic [NUM_REQ*64-1:0]     src_tdata_in,
  input  logic [NUM_REQ*8-1:0]      src_tkeep_in,
  input  logic [NUM_REQ-1:0]        src_tvalid_in,
  input  logic [NUM_REQ-1:0]        src_tlast_in,
  output logic [NUM_REQ-1:0]        src_tready_o,
  srio_nwr_scheduler_if.master      eng
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 8191) begin : g_param_chk
    $error("srio_nwr_scheduler: NUM_REQ or TIMEOUT_CYC out of range");
  end

  sched_state_t          state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      gidx;
  logic [LEN_W-1:0]      job_len;
  logic [WIN_LOG2-1:0]   offset [NUM_REQ];

  logic [NUM_REQ-1:0]    arb_onehot;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic [LEN_W-1:0]      cand_len;
  logic [ADDR_W-1:0]     cand_base;
  logic                  len_ok;
  logic [WIN_LOG2-1:0]   off_next;
  logic                  beat_last;
  logic                  wd_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req_in),
    .ptr   (rr_ptr),
    .grant (arb_onehot),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + IDX_W'(1);
  endfunction

  always_comb begin
    cand_len  = len_in[arb_idx*LEN_W +: LEN_W];
    cand_base = base_addr_in[arb_idx*ADDR_W +: ADDR_W];
    len_ok    = (cand_len != '0) && (cand_len <= LEN_W'(MAX_LEN));
    // Truncation to the window width gives the modulo-2^WIN_LOG2 wrap.
    off_next  = offset[gidx] + WIN_LOG2'(ceil8(job_len));
  end

`ifdef SRIO_NWR_SCHED_TIMEOUT_EN
  logic [12:0] wd_cnt;

  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n)              wd_cnt <= '0;
    else if (state == WAIT_DONE) wd_cnt <= wd_cnt + 13'd1;
    else                         wd_cnt <= '0;
  end

  assign wd_hit = (state == WAIT_DONE) && (wd_cnt == 13'(TIMEOUT_CYC - 1));
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      gidx             <= '0;
      job_len          <= '0;
      grant_o          <= '0;
      done_o           <= '0;
      err_o            <= '0;
      eng.user_addr_o  <= '0;
      eng.user_tsize_o <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) offset[i] <= '0;
    end else begin
      done_o <= '0;
      err_o  <= '0;
      case (state)
        IDLE: if (|req_in && eng.rapidIO_ready_in) state <= ARB;
        ARB: begin
          if (!arb_any) begin
            state <= IDLE;
          end else if (!len_ok) begin
            err_o  <= arb_onehot;
            rr_ptr <= ptr_inc(arb_idx);
            state  <= IDLE;
          end else begin
            grant_o          <= arb_onehot;
            gidx             <= arb_idx;
            job_len          <= cand_len;
            eng.user_addr_o  <= cand_base | ADDR_W'(offset[arb_idx]);
            eng.user_tsize_o <= TSIZE_W'(cand_len - LEN_W'(1));
            state            <= REQ;
          end
        end
        REQ:  if (eng.nwr_busy_in) state <= XFER;
        XFER: if (beat_last) state <= WAIT_DONE;
        WAIT_DONE: begin
          if (eng.nwr_done_ack_in) begin
            done_o       <= grant_o;
            offset[gidx] <= off_next;
            rr_ptr       <= ptr_inc(gidx);
            grant_o      <= '0;
            state        <= IDLE;
          end else if (wd_hit) begin
            err_o   <= grant_o;
            rr_ptr  <= ptr_inc(gidx);
            grant_o <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign eng.nwr_req_o = (state == REQ) && eng.nwr_ready_in && eng.rapidIO_ready_in;
  assign beat_last     = eng.user_tvalid_o && eng.user_tready_in && eng.user_tlast_o;

  always_comb begin
    eng.user_tdata_o  = '0;
    eng.user_tkeep_o  = '0;
    eng.user_tvalid_o = 1'b0;
    eng.user_tlast_o  = 1'b0;
    src_tready_o      = '0;
    if (state == XFER) begin
      eng.user_tdata_o   = src_tdata_in[gidx*64 +: 64];
      eng.user_tkeep_o   = src_tkeep_in[gidx*8 +: 8];
      eng.user_tvalid_o  = src_tvalid_in[gidx];
      eng.user_tlast_o   = src_tlast_in[gidx];
      src_tready_o[gidx] = eng.user_tready_in;
    end
  end

endmodule
